uart_rx: RTL
============

Name: uart_rx

Overview:
- 8x-oversampling UART receiver, directly downstream of the baud-rate enable generator.
- Consumes the generator's rx_bd_en tick (one clk-wide pulse at 8 × baud) and the asynchronous serial line rxd.
- Emits one parallel byte per received frame with a single-cycle valid strobe.
- Detects framing errors and reports them with a single-cycle error strobe.

Parameters:
- DATA_BITS, 8, data bits per frame, 5..8, LSB first.
- OVERSAMPLE, 8, rx_bd_en ticks per bit period; must be even and ≥ 6.

Ports:
- clk  input  1  system clock (50 MHz on the target board).
- rst_n  input  1  reset, synchronous, active-low.
- rx_bd_en  input  1  oversample tick, one clk wide, from the baud-rate generator.
- rxd  input  1  asynchronous serial line; idles high.
- rx_data  output  DATA_BITS  last correctly framed byte.
- rx_valid  output  1  one-clk pulse when rx_data updates.
- rx_frame_err  output  1  one-clk pulse when the stop bit is sampled low.
- rx_busy  output  1  high while a frame is in progress (any state other than IDLE).

Behaviour:
- Reset: synchronous, active-low, sampled on the posedge of clk.
  - rx_data = 0, rx_valid = 0, rx_frame_err = 0, rx_busy = 0.
  - Synchroniser flops = 1, all counters = 0, state = IDLE.
- Input synchroniser: rxd passes through a 2-flop synchroniser (rxd_s) before any use; this adds 2 clk of latency.
- Timing: all state and counter activity advances only on clk edges where rx_bd_en = 1, except the rx_valid/rx_frame_err pulse clear, which happens on the next clk regardless of rx_bd_en.
- Tick counter tcnt: 0..OVERSAMPLE-1, wraps to 0.
- Bit counter bcnt: 0..DATA_BITS-1.
- Majority sample: on ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1, rxd_s is shifted into a 3-bit vote register. The bit value is the majority (≥ 2 ones) and is evaluated at tick OVERSAMPLE/2+1.
- FSM (states IDLE, START, DATA, STOP, BREAK):
  - IDLE: when rxd_s = 0 at a tick, set tcnt = 0 and go to START.
  - START: at the vote point:
    - vote = 0 → valid start bit; continue to the end of the bit, then tcnt = 0, bcnt = 0, go to DATA.
    - vote = 1 → glitch; return to IDLE immediately with no strobe.
  - DATA: at each vote point, shift the voted bit into the MSB of the shift register (right shift, so LSB-first arrival ends up correctly ordered). At tcnt = OVERSAMPLE-1, increment bcnt. After bit DATA_BITS-1, go to STOP (or PARITY, see Optional Feature).
  - STOP: at the vote point:
    - vote = 1 → load rx_data from the shift register, pulse rx_valid for 1 clk, go to IDLE. Do not wait for the end of the stop bit; this permits back-to-back frames.
    - vote = 0 → pulse rx_frame_err for 1 clk, leave rx_data unchanged, go to BREAK.
  - BREAK: stay until rxd_s = 1 at a tick, then go to IDLE. This prevents a held-low line from being re-detected as repeated start bits.
- Latency: rx_valid asserts at the stop-bit vote point, about 1.5 + DATA_BITS + 0.1 bit times after the start edge, plus 2 clk for the synchroniser.
- Strobe exclusivity: rx_valid and rx_frame_err are never high in the same cycle.
- Reset mid-frame: returns to IDLE on the next clk with no strobe; the partial byte is discarded.
- Rate tolerance: with a 50 MHz clock and 115200 baud, rx_bd_en arrives every 54 clk, giving a 432-clk bit versus a nominal 434 clk. The receiver must decode correctly with up to ±3% baud mismatch.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds parameter PARITY_ODD (default 0 = even parity) and output rx_parity_err (1 bit, one-clk pulse, reset 0).
  - Adds a PARITY state between DATA and STOP that samples the parity bit with the same majority vote.
  - A mismatch is latched. At STOP with vote = 1, a latched mismatch produces an rx_parity_err pulse in place of rx_valid, and rx_data is not updated.
  - Framing error takes precedence over parity error.
- Undefined:
  - No PARITY state, no rx_parity_err port.
  - The frame is start + DATA_BITS + stop.

Test Plan:
- Reset then idle: hold rst_n = 0 for 3 clk, then rxd = 1 for 2000 clk → all outputs stay 0 and rx_busy = 0.
- Single frame: send 0xA5 at 115200 (434 clk/bit, 50 MHz clk) → exactly one rx_valid pulse, rx_data = 0xA5, no rx_frame_err.
- Back-to-back: send 0x00, 0xFF, 0x55 with no idle gap → three rx_valid pulses with rx_data = 0x00, 0xFF, 0x55 in order.
- Glitch rejection: a 100-clk low pulse on an idle rxd → no strobe, and the FSM returns to IDLE with rx_busy = 0 within 1 bit time.
- Framing error and break:
  - Send 0x3C with the stop bit forced low → rx_frame_err pulse and rx_data unchanged.
  - Then hold rxd = 0 for 5 bit times → no further strobes.
  - Release rxd and send 0x81 → rx_valid with rx_data = 0x81.
- Tolerance and reset: send 0x5A at a bit period of 421 clk and then 447 clk (±3%) → rx_data = 0x5A both times. Then assert rst_n = 0 mid-frame during bit 4 → no strobe, outputs = 0, and the next full frame 0x12 is received correctly.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8x-oversampled UART receiver with 2-flop input synchroniser and
// 3-sample majority vote per bit. Optional parity checking is built when
// UART_RX_PARITY_EN is defined (adds PARITY_ODD and rx_parity_err).
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 8
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_bd_en,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_frame_err,
`ifdef UART_RX_PARITY_EN
    output logic                 rx_parity_err,
`endif
    output logic                 rx_busy
);

    localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TW-1:0] T_VLO  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_VHI  = TW'(OVERSAMPLE / 2 + 1);
    localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    state_t                 state, state_nxt;
    logic                   rxd_m, rxd_s;
    logic [TW-1:0]          tcnt, tcnt_nxt, tcnt_inc;
    logic [BW-1:0]          bcnt, bcnt_nxt;
    logic [1:0]             vote_q;       // first two samples of the window
    logic                   vote_maj;
    logic                   in_win, vote_pt;
    logic [DATA_BITS-1:0]   shreg;
    logic                   shift_en, load_en, ferr_set;
`ifdef UART_RX_PARITY_EN
    logic                   pchk_en, perr_set, par_lat;
`endif

    // The third vote sample is the live synchronised line at the vote tick.
    assign vote_maj = (vote_q[1] & vote_q[0]) | (vote_q[1] & rxd_s) | (vote_q[0] & rxd_s);
    assign in_win   = (tcnt >= T_VLO) && (tcnt <= T_VHI);
    assign vote_pt  = (tcnt == T_VHI);
    assign tcnt_inc = (tcnt == T_LAST) ? '0 : tcnt + 1'b1;
    assign rx_busy  = (state != S_IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state, counter next values and one-tick action strobes.
    always_comb begin
        state_nxt = state;
        tcnt_nxt  = tcnt;
        bcnt_nxt  = bcnt;
        shift_en  = 1'b0;
        load_en   = 1'b0;
        ferr_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
        pchk_en   = 1'b0;
        perr_set  = 1'b0;
`endif
        if (rx_bd_en) begin
            case (state)
                S_IDLE: begin
                    if (!rxd_s) begin
                        tcnt_nxt  = '0;
                        state_nxt = S_START;
                    end
                end
                S_START: begin
                    tcnt_nxt = tcnt_inc;
                    if (vote_pt && vote_maj) begin
                        // Start bit did not hold: treat as a glitch.
                        tcnt_nxt  = '0;
                        state_nxt = S_IDLE;
                    end else if (tcnt == T_LAST) begin
                        bcnt_nxt  = '0;
                        state_nxt = S_DATA;
                    end
                end
                S_DATA: begin
                    tcnt_nxt = tcnt_inc;
                    if (vote_pt) shift_en = 1'b1;
                    if (tcnt == T_LAST) begin
                        if (bcnt == B_LAST) begin
                            bcnt_nxt  = '0;
`ifdef UART_RX_PARITY_EN
                            state_nxt = S_PARITY;
`else
                            state_nxt = S_STOP;
`endif
                        end else begin
                            bcnt_nxt = bcnt + 1'b1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    tcnt_nxt = tcnt_inc;
                    if (vote_pt) pchk_en = 1'b1;
                    if (tcnt == T_LAST) state_nxt = S_STOP;
                end
`endif
                S_STOP: begin
                    tcnt_nxt = tcnt_inc;
                    // Decide at the vote point so a following start bit is not missed.
                    if (vote_pt) begin
                        tcnt_nxt = '0;
                        if (vote_maj) begin
                            state_nxt = S_IDLE;
`ifdef UART_RX_PARITY_EN
                            if (par_lat) perr_set = 1'b1;
                            else         load_en  = 1'b1;
`else
                            load_en = 1'b1;
`endif
                        end else begin
                            ferr_set  = 1'b1;
                            state_nxt = S_BREAK;
                        end
                    end
                end
                S_BREAK: begin
                    if (rxd_s) state_nxt = S_IDLE;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Synchroniser, counters, vote/shift registers and output strobes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rxd_m        <= 1'b1;
            rxd_s        <= 1'b1;
            tcnt         <= '0;
            bcnt         <= '0;
            vote_q       <= '0;
            shreg        <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            rxd_m        <= rxd;
            rxd_s        <= rxd_m;
            tcnt         <= tcnt_nxt;
            bcnt         <= bcnt_nxt;
            rx_valid     <= load_en;
            rx_frame_err <= ferr_set;
            if (rx_bd_en && state != S_IDLE && state != S_BREAK && in_win)
                vote_q <= {vote_q[0], rxd_s};
            if (shift_en) shreg <= {vote_maj, shreg[DATA_BITS-1:1]};
            if (load_en)  rx_data <= shreg;
        end
    end

`ifdef UART_RX_PARITY_EN
    // Parity mismatch latch, cleared at each new start bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            par_lat       <= 1'b0;
            rx_parity_err <= 1'b0;
        end else begin
            rx_parity_err <= perr_set;
            if (state == S_IDLE && state_nxt == S_START) par_lat <= 1'b0;
            else if (pchk_en) par_lat <= ((^shreg) ^ vote_maj) != PARITY_ODD;
        end
    end
`endif

endmodule
